l1an_hdr_builder: RTL and testbench

- Consumer stage directly downstream of the L1A-number FIFO.
- Waits for a queued L1A entry, lets the FIFO's block-RAM read port settle, then captures the 6-bit L1A number and phase bit and pops the entry.
- Sends a 3-word event header to the readout mux over a valid/ack handshake.
- Starts and waits out the sample-data transfer for that event.
- Checks the L1A number against the expected sequence.

---
 rtl/l1an_hdr_builder.sv | 198 +++++++++++++++++++
 tb/tb_l1an_hdr_builder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l1an_hdr_builder.sv
// l1an_hdr_builder: pops L1A-number FIFO entries, emits a 3-word event
// header over a valid/ack handshake, runs the sample transfer for the event
// and checks the L1A numbers against the expected running sequence.
module l1an_hdr_builder #(
    parameter int         TMR      = 0,
    parameter logic [3:0] BOARD_ID = 4'h0,
    parameter int         SETTLE   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FIFO_EMPTY,
    input  logic [5:0]  L1ANUM,
    input  logic        L1A_PHASE_IN,
    output logic        POP,
    output logic        HDR_VLD,
    output logic [15:0] HDR_WORD,
    input  logic        HDR_ACK,
    output logic        EVT_REQ,
    input  logic        EVT_DONE,
    output logic [7:0]  EVT_CNT,
    output logic        SEQ_ERR,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CAPT   = 3'd2,
        S_H0     = 3'd3,
        S_H1     = 3'd4,
        S_H2     = 3'd5,
        S_XFER   = 3'd6,
        S_GAP    = 3'd7
    } state_t;

    localparam int         NCP       = (TMR != 0) ? 3 : 1;
    localparam logic [2:0] SETTLE_LD = 3'(SETTLE);

    // Voted (or single-copy) views of the protected registers
    logic [2:0] state_cp [NCP];
    logic [7:0] cnt_cp   [NCP];
    logic [5:0] exp_cp   [NCP];
    logic [2:0] state_v;
    logic [7:0] cnt_v;
    logic [5:0] exp_v;
    state_t     state_cur;

    // Next-state values shared by every copy
    state_t     state_d;
    logic [7:0] evt_cnt_d;
    logic [5:0] exp_d;

    // Unprotected registers
    logic [2:0]  settle_q, settle_d;
    logic [5:0]  l1anum_q, l1anum_d;
    logic        phase_q, phase_d;
    logic        seq_err_q, seq_err_d;
    logic        pop_q, pop_d;
    logic        hdr_vld_q, hdr_vld_d;
    logic [15:0] hdr_word_q, hdr_word_d;
    logic        evt_req_q, evt_req_d;

    genvar gi;
    generate
        for (gi = 0; gi < NCP; gi++) begin : g_cp
            logic [2:0] st_q;
            logic [7:0] cnt_q;
            logic [5:0] exp_q;

            // One copy of state / event counter / expected number; every copy
            // reloads from the voted next value so an upset heals in one cycle
            always_ff @(posedge CLK) begin
                if (RST) begin
                    st_q  <= S_IDLE;
                    cnt_q <= 8'h00;
                    exp_q <= 6'd0;
                end else begin
                    st_q  <= state_d;
                    cnt_q <= evt_cnt_d;
                    exp_q <= exp_d;
                end
            end

            assign state_cp[gi] = st_q;
            assign cnt_cp[gi]   = cnt_q;
            assign exp_cp[gi]   = exp_q;
        end

        if (NCP == 3) begin : g_vote
            assign state_v = (state_cp[0] & state_cp[1]) | (state_cp[0] & state_cp[2])
                           | (state_cp[1] & state_cp[2]);
            assign cnt_v   = (cnt_cp[0] & cnt_cp[1]) | (cnt_cp[0] & cnt_cp[2])
                           | (cnt_cp[1] & cnt_cp[2]);
            assign exp_v   = (exp_cp[0] & exp_cp[1]) | (exp_cp[0] & exp_cp[2])
                           | (exp_cp[1] & exp_cp[2]);
        end else begin : g_single
            assign state_v = state_cp[0];
            assign cnt_v   = cnt_cp[0];
            assign exp_v   = exp_cp[0];
        end
    endgenerate

    assign state_cur = state_t'(state_v);

    // Next-state, capture/check and registered-output decode
    always_comb begin
        state_d    = state_cur;
        evt_cnt_d  = cnt_v;
        exp_d      = exp_v;
        settle_d   = settle_q;
        l1anum_d   = l1anum_q;
        phase_d    = phase_q;
        seq_err_d  = seq_err_q;
        hdr_word_d = 16'h0000;

        case (state_cur)
            S_IDLE: begin
                if (!FIFO_EMPTY) begin
                    settle_d = SETTLE_LD;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q - 3'd1;
                // Entry vanished: never pop an empty FIFO
                if (FIFO_EMPTY) begin
                    state_d = S_IDLE;
                end else if (settle_q <= 3'd1) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                l1anum_d = L1ANUM;
                phase_d  = L1A_PHASE_IN;
                if (L1ANUM != exp_v) begin
                    seq_err_d = 1'b1;
                end
                // Resync to the observed number so a single skip flags once
                exp_d   = L1ANUM + 6'd1;
                state_d = S_H0;
            end
            S_H0:   if (HDR_ACK) state_d = S_H1;
            S_H1:   if (HDR_ACK) state_d = S_H2;
            S_H2:   if (HDR_ACK) state_d = S_XFER;
            S_XFER: begin
                if (EVT_DONE) begin
                    evt_cnt_d = cnt_v + 8'd1;
                    state_d   = S_GAP;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step
        pop_d     = (state_d == S_CAPT);
        hdr_vld_d = (state_d == S_H0) || (state_d == S_H1) || (state_d == S_H2);
        evt_req_d = (state_d == S_XFER);
        case (state_d)
            S_H0:    hdr_word_d = {4'h9, 5'b00000, phase_d, l1anum_d};
            S_H1:    hdr_word_d = {4'hA, 4'h0, cnt_v};
            S_H2:    hdr_word_d = {4'hB, BOARD_ID, 8'h00};
            default: hdr_word_d = 16'h0000;
        endcase
    end

    // Registers outside the protected set
    always_ff @(posedge CLK) begin
        if (RST) begin
            settle_q   <= 3'd0;
            l1anum_q   <= 6'd0;
            phase_q    <= 1'b0;
            seq_err_q  <= 1'b0;
            pop_q      <= 1'b0;
            hdr_vld_q  <= 1'b0;
            hdr_word_q <= 16'h0000;
            evt_req_q  <= 1'b0;
        end else begin
            settle_q   <= settle_d;
            l1anum_q   <= l1anum_d;
            phase_q    <= phase_d;
            seq_err_q  <= seq_err_d;
            pop_q      <= pop_d;
            hdr_vld_q  <= hdr_vld_d;
            hdr_word_q <= hdr_word_d;
            evt_req_q  <= evt_req_d;
        end
    end

    assign POP      = pop_q;
    assign HDR_VLD  = hdr_vld_q;
    assign HDR_WORD = hdr_word_q;
    assign EVT_REQ  = evt_req_q;
    assign EVT_CNT  = cnt_v;
    assign SEQ_ERR  = seq_err_q;
    assign BUSY     = (state_cur != S_IDLE);

endmodule

// File: tb/tb_l1an_hdr_builder.sv
// Directed bench for l1an_hdr_builder: FIFO model, auto EVT_DONE responder,
// header/pop monitors and linear directed steps with hand-computed values.
module tb_l1an_hdr_builder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FIFO_EMPTY;
    logic [5:0]  L1ANUM;
    logic        L1A_PHASE_IN;
    logic        POP;
    logic        HDR_VLD;
    logic [15:0] HDR_WORD;
    logic        HDR_ACK = 1'b1;
    logic        EVT_REQ;
    logic        EVT_DONE = 1'b0;
    logic [7:0]  EVT_CNT;
    logic        SEQ_ERR;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    l1an_hdr_builder #(.TMR(1), .BOARD_ID(4'h0), .SETTLE(2)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .FIFO_EMPTY   (FIFO_EMPTY),
        .L1ANUM       (L1ANUM),
        .L1A_PHASE_IN (L1A_PHASE_IN),
        .POP          (POP),
        .HDR_VLD      (HDR_VLD),
        .HDR_WORD     (HDR_WORD),
        .HDR_ACK      (HDR_ACK),
        .EVT_REQ      (EVT_REQ),
        .EVT_DONE     (EVT_DONE),
        .EVT_CNT      (EVT_CNT),
        .SEQ_ERR      (SEQ_ERR),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    // FIFO model: entry = {phase, l1anum}; pushes from the stimulus, pops on POP
    logic [6:0] fifo_mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign FIFO_EMPTY   = (rd_ptr == wr_ptr);
    assign L1ANUM       = fifo_mem[rd_ptr][5:0];
    assign L1A_PHASE_IN = fifo_mem[rd_ptr][6];

    // Monitors: pop count, pops on empty, min pop spacing, accepted header words
    int          cyc = 0;
    int          npop = 0;
    int          pop_empty = 0;
    int          last_pop = 0;
    int          min_gap = 1000;
    int          hdr_n = 0;
    logic [15:0] hdr_log [512];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (POP) begin
            if (npop > 0 && (cyc - last_pop) < min_gap) min_gap <= cyc - last_pop;
            last_pop <= cyc;
            npop     <= npop + 1;
            if (rd_ptr == wr_ptr) pop_empty <= pop_empty + 1;
            else                  rd_ptr <= rd_ptr + 1;
        end
        if (HDR_VLD && HDR_ACK) begin
            hdr_log[hdr_n] <= HDR_WORD;
            hdr_n          <= hdr_n + 1;
        end
    end

    // Sample-transfer responder: EVT_DONE pulse 3 cycles into EVT_REQ
    logic done_en = 1'b1;
    initial begin
        int req_cyc;
        req_cyc = 0;
        forever begin
            @(negedge CLK);
            if (EVT_DONE) begin
                EVT_DONE = 1'b0;
                req_cyc  = 0;
            end else if (EVT_REQ && done_en) begin
                req_cyc++;
                if (req_cyc >= 3) EVT_DONE = 1'b1;
            end else begin
                req_cyc = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [6:0] v);
        fifo_mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Wait (bounded) until target pops are done and the block is idle
    task automatic wait_evt(input int target, input string tag);
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (npop >= target && !BUSY && FIFO_EMPTY) break;
        end
        chk(tag, 32'(npop), 32'(target));
        chk({tag, "_idle"}, {31'b0, BUSY}, 32'd0);
    endtask

    initial begin
        int          base;
        logic [15:0] e;
        logic [5:0]  nums    [4];
        logic        err_exp [4];
        nums    = '{6'd0, 6'd1, 6'd5, 6'd6};
        err_exp = '{1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ctrl", {27'b0, POP, HDR_VLD, EVT_REQ, SEQ_ERR, BUSY}, 32'd0);
        chk("rst_word", {16'b0, HDR_WORD}, 32'h0000);
        chk("rst_cnt", {24'b0, EVT_CNT}, 32'd0);

        // Single event: L1ANUM=0, phase=1, cycle-exact latency
        RST = 1'b0;
        @(negedge CLK);
        push(7'h40);
        @(negedge CLK); chk("t1_c1", {30'b0, POP, BUSY}, 32'b01);
        @(negedge CLK); chk("t1_c2", {30'b0, POP, BUSY}, 32'b01);
        @(negedge CLK); chk("t1_pop", {31'b0, POP}, 32'd1);
        @(negedge CLK); chk("t1_h0", {14'b0, POP, HDR_VLD, HDR_WORD}, {14'b0, 2'b01, 16'h9040});
        @(negedge CLK); chk("t1_h1", {16'b0, HDR_WORD}, 32'hA000);
        @(negedge CLK); chk("t1_h2", {16'b0, HDR_WORD}, 32'hB000);
        @(negedge CLK); chk("t1_xfer", {30'b0, HDR_VLD, EVT_REQ}, 32'b01);
        wait_evt(1, "t1_done");
        chk("t1_cnt", {24'b0, EVT_CNT}, 32'd1);
        chk("t1_seq", {31'b0, SEQ_ERR}, 32'd0);

        // 66 back-to-back entries, L1A number wraps 63 -> 0
        do_reset();
        base = hdr_n;
        for (int i = 0; i < 66; i++) push({i[0], 6'(i % 64)});
        wait_evt(67, "t2_done");
        chk("t2_cnt", {24'b0, EVT_CNT}, 32'd66);
        chk("t2_seq", {31'b0, SEQ_ERR}, 32'd0);
        chk("t2_nhdr", 32'(hdr_n - base), 32'd198);
        for (int i = 0; i < 66; i++) begin
            e = {4'h9, 5'b0, i[0], 6'(i % 64)};
            chk($sformatf("t2_h0_%0d", i), {16'b0, hdr_log[base + 3*i]}, {16'b0, e});
            e = {8'hA0, 8'(i)};
            chk($sformatf("t2_h1_%0d", i), {16'b0, hdr_log[base + 3*i + 1]}, {16'b0, e});
            chk($sformatf("t2_h2_%0d", i), {16'b0, hdr_log[base + 3*i + 2]}, 32'hB000);
        end
        chk("t2_gap", {31'b0, (min_gap >= 3)}, 32'd1);

        // Sequence 0,1,5,6: error at 5, sticky, resync on 6
        do_reset();
        for (int k = 0; k < 4; k++) begin
            base = npop + 1;
            push({1'b0, nums[k]});
            wait_evt(base, $sformatf("t3_done_%0d", k));
            chk($sformatf("t3_seq_%0d", k), {31'b0, SEQ_ERR}, {31'b0, err_exp[k]});
            chk($sformatf("t3_h0_%0d", k), {16'b0, hdr_log[hdr_n - 3]}, {26'h0000240, nums[k]});
        end
        chk("t3_cnt", {24'b0, EVT_CNT}, 32'd4);

        // HDR_ACK stalls: hold H1 for 10 cycles, then H2 for 1
        HDR_ACK = 1'b0;
        base = npop + 1;
        push(7'h07);
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (HDR_VLD) break;
        end
        chk("t4_h0", {15'b0, HDR_VLD, HDR_WORD}, {15'b0, 1'b1, 16'h9007});
        HDR_ACK = 1'b1;
        @(negedge CLK);
        HDR_ACK = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk($sformatf("t4_hold_%0d", c), {13'b0, POP, EVT_REQ, HDR_VLD, HDR_WORD},
                {13'b0, 3'b001, 16'hA004});
        end
        HDR_ACK = 1'b1;
        @(negedge CLK);
        HDR_ACK = 1'b0;
        chk("t4_h2", {14'b0, EVT_REQ, HDR_VLD, HDR_WORD}, {14'b0, 2'b01, 16'hB000});
        @(negedge CLK);
        chk("t4_h2_hold", {14'b0, EVT_REQ, HDR_VLD, HDR_WORD}, {14'b0, 2'b01, 16'hB000});
        HDR_ACK = 1'b1;
        @(negedge CLK);
        chk("t4_xfer", {30'b0, EVT_REQ, HDR_VLD}, 32'b10);
        wait_evt(base, "t4_done");
        chk("t4_cnt", {24'b0, EVT_CNT}, 32'd5);

        // Reset during XFER with two entries still queued
        done_en = 1'b0;
        base = npop;
        push(7'd20);
        push(7'd0);
        push(7'd1);
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (EVT_REQ) break;
        end
        chk("t5_in_xfer", {31'b0, EVT_REQ}, 32'd1);
        chk("t5_pop1", 32'(npop - base), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_rst_ctrl", {27'b0, POP, HDR_VLD, EVT_REQ, SEQ_ERR, BUSY}, 32'd0);
        chk("t5_rst_word", {16'b0, HDR_WORD}, 32'h0000);
        chk("t5_rst_cnt", {24'b0, EVT_CNT}, 32'd0);
        repeat (2) @(negedge CLK);
        chk("t5_nopop_rst", 32'(npop - base), 32'd1);
        RST = 1'b0;
        done_en = 1'b1;
        wait_evt(base + 3, "t5_done");
        chk("t5_cnt", {24'b0, EVT_CNT}, 32'd2);
        chk("t5_seq", {31'b0, SEQ_ERR}, 32'd0);
        chk("t5_h0a", {16'b0, hdr_log[hdr_n - 6]}, 32'h9000);
        chk("t5_h0b", {16'b0, hdr_log[hdr_n - 3]}, 32'h9001);
        chk("pop_on_empty", 32'(pop_empty), 32'd0);
        chk("pop_spacing", {31'b0, (min_gap >= 3)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
